// File: rtl/spi_pkg.sv
// Shared types and helpers for the parametrised SPI master.
package spi_pkg;

    // Transfer sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_GAP   = 3'd3,
        ST_HOLD  = 3'd4
    } spi_state_t;

    // SPI modes encoded as {cpol, cpha}.
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    // Width of the chip-select index; never narrower than one bit.
    function automatic int cs_width(input int num_cs);
        return (num_cs > 1) ? $clog2(num_cs) : 1;
    endfunction

endpackage

// File: rtl/spi_master_param_if.sv
// Host-side bus of the SPI master (register slave / TX FIFO side).
//
// Handshake: the host raises start with tx_data and the configuration
// valid. The core accepts start only while idle and not on its done cycle;
// acceptance is signalled one cycle later by a single-cycle tx_ack, with
// busy high from that cycle until the done cycle. done is a single-cycle
// pulse; rx_data is valid from done and held until the next done. A start
// seen while busy is dropped without tx_ack.
interface spi_master_param_if #(
    parameter int DATA_W = 32,
    parameter int DIV_W  = 8,
    parameter int CS_W   = 1
);
    logic              start;
    logic [DATA_W-1:0] tx_data;
    logic              cpol;
    logic              cpha;
    logic              lsb_first;
    logic              cs_toggle;
    logic [DIV_W-1:0]  clk_div;
    logic [CS_W-1:0]   cs_sel;
    logic              tx_ack;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rx_data;

    modport master (
        output start, tx_data, cpol, cpha, lsb_first, cs_toggle, clk_div, cs_sel,
        input  tx_ack, busy, done, rx_data
    );

    modport slave (
        input  start, tx_data, cpol, cpha, lsb_first, cs_toggle, clk_div, cs_sel,
        output tx_ack, busy, done, rx_data
    );
endinterface

// File: rtl/spi_clk_gen.sv
// Half-period tick generator: while enabled, o_tick pulses every
// i_div+1 cycles. The counter restarts from zero whenever disabled.
module spi_clk_gen #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [DIV_W-1:0] i_div,
    input  logic             i_en,
    output logic             o_tick
);

    logic [DIV_W-1:0] r_cnt;
    logic             w_tick;

    // Terminal count at i_div, so the counter never reaches past its width.
    assign w_tick = i_en && (r_cnt == i_div);
    assign o_tick = w_tick;

    // Count cycles within the current half period.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (!i_en || w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/spi_master_param.sv
// Parametrised SPI master: runtime CPOL/CPHA, SCLK divider, bit order,
// multiple chip selects with optional release between characters.
module spi_master_param
    import spi_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CHAR_W = 8,
    parameter int NUM_CS = 1,
    parameter int DIV_W  = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    spi_master_param_if.slave  bus,
    output logic               o_sclk,
    output logic [NUM_CS-1:0]  o_ss_n,
    output logic               o_mosi,
    input  logic               i_miso,
    output spi_state_t         o_state
);

    localparam int CS_W = cs_width(NUM_CS);
    localparam int BW   = $clog2(DATA_W + 1);
    localparam int IW   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int CB   = $clog2(CHAR_W + 1);

    generate
        if (DATA_W % CHAR_W != 0) begin : g_bad_char_w
            $error("DATA_W must be a multiple of CHAR_W");
        end
    endgenerate

    spi_state_t        r_state;
    logic [DATA_W-1:0] r_tx;
    logic [DATA_W-1:0] r_rx;
    logic [DATA_W-1:0] r_rx_data;
    logic              r_cpol;
    logic              r_cpha;
    logic              r_lsb;
    logic              r_toggle;
    logic [DIV_W-1:0]  r_div;
    logic [CS_W-1:0]   r_cs_sel;
    logic [BW-1:0]     r_bit_cnt;
    logic [CB-1:0]     r_char_bit;
    logic              r_half;
    logic              r_sclk;
    logic [NUM_CS-1:0] r_ss_n;
    logic              r_mosi;
    logic              r_tx_ack;
    logic              r_busy;
    logic              r_done;

    logic              w_tick;
    logic              w_lead;
    logic [IW-1:0]     w_cur_idx;
    logic [IW-1:0]     w_nxt_idx;

    // Word bit position of the n-th bit on the wire.
    function automatic logic [IW-1:0] f_idx(input logic [BW-1:0] n, input logic lsb);
        logic [BW-1:0] m;
        m = lsb ? n : (BW'(DATA_W - 1) - n);
        return m[IW-1:0];
    endfunction

    // Active-low select pattern; an out-of-range index selects nothing.
    function automatic logic [NUM_CS-1:0] f_cs_low(input logic [CS_W-1:0] sel);
        logic [NUM_CS-1:0] v;
        v = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (sel == CS_W'(i)) v[i] = 1'b0;
        end
        return v;
    endfunction

    spi_clk_gen #(.DIV_W(DIV_W)) u_clk_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .i_div   (r_div),
        .i_en    (r_state != ST_IDLE),
        .o_tick  (w_tick)
    );

    assign w_cur_idx = f_idx(r_bit_cnt, r_lsb);
    assign w_nxt_idx = f_idx(r_bit_cnt + BW'(1), r_lsb);

    // A leading SCLK edge starts each bit: out of SETUP, out of GAP, or
    // after the second half of a bit that is not the last of its character.
    assign w_lead = w_tick && ((r_state == ST_SETUP) || (r_state == ST_GAP) ||
                    ((r_state == ST_SHIFT) && r_half &&
                     (r_bit_cnt != BW'(DATA_W)) && (r_char_bit != CB'(CHAR_W))));

    // Transfer sequencer with registered SPI pins and handshake outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_tx       <= '0;
            r_rx       <= '0;
            r_rx_data  <= '0;
            r_cpol     <= 1'b0;
            r_cpha     <= 1'b0;
            r_lsb      <= 1'b0;
            r_toggle   <= 1'b0;
            r_div      <= '0;
            r_cs_sel   <= '0;
            r_bit_cnt  <= '0;
            r_char_bit <= '0;
            r_half     <= 1'b0;
            r_sclk     <= 1'b0;
            r_ss_n     <= '1;
            r_mosi     <= 1'b0;
            r_tx_ack   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_tx_ack <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_sclk <= bus.cpol;
                    // No acceptance on the done cycle itself.
                    if (bus.start && !r_done) begin
                        r_tx       <= bus.tx_data;
                        r_cpol     <= bus.cpol;
                        r_cpha     <= bus.cpha;
                        r_lsb      <= bus.lsb_first;
                        r_toggle   <= bus.cs_toggle;
                        r_div      <= bus.clk_div;
                        r_cs_sel   <= bus.cs_sel;
                        r_rx       <= '0;
                        r_bit_cnt  <= '0;
                        r_char_bit <= '0;
                        r_half     <= 1'b0;
                        r_mosi     <= bus.lsb_first ? bus.tx_data[0] : bus.tx_data[DATA_W-1];
                        r_ss_n     <= f_cs_low(bus.cs_sel);
                        r_tx_ack   <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (w_tick) r_state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (w_tick) begin
                        if (!r_half) begin
                            // Trailing edge.
                            r_sclk     <= r_cpol;
                            r_half     <= 1'b1;
                            r_bit_cnt  <= r_bit_cnt + BW'(1);
                            r_char_bit <= r_char_bit + CB'(1);
                            if (r_cpha) begin
                                r_rx[w_cur_idx] <= i_miso;
                            end else if (r_bit_cnt != BW'(DATA_W - 1)) begin
                                r_mosi <= r_tx[w_nxt_idx];
                            end
                        end else if (r_bit_cnt == BW'(DATA_W)) begin
                            r_state <= ST_HOLD;
                        end else if (r_char_bit == CB'(CHAR_W)) begin
                            r_state    <= ST_GAP;
                            r_char_bit <= '0;
                            if (r_toggle) r_ss_n <= '1;
                        end
                    end
                end
                ST_GAP: begin
                    if (w_tick) begin
                        r_ss_n  <= f_cs_low(r_cs_sel);
                        r_state <= ST_SHIFT;
                    end
                end
                ST_HOLD: begin
                    if (w_tick) begin
                        r_ss_n    <= '1;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_rx_data <= r_rx;
                        r_state   <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            // Leading-edge actions shared by every entry into a bit.
            if (w_lead) begin
                r_sclk <= ~r_cpol;
                r_half <= 1'b0;
                if (r_cpha) begin
                    r_mosi <= r_tx[w_cur_idx];
                end else begin
                    r_rx[w_cur_idx] <= i_miso;
                end
            end
        end
    end

    assign o_sclk      = r_sclk;
    assign o_ss_n      = r_ss_n;
    assign o_mosi      = r_mosi;
    assign o_state     = r_state;
    assign bus.tx_ack  = r_tx_ack;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.rx_data = r_rx_data;

endmodule
